nv_host_int_evarb: RTL and testbench
====================================

Name: nv_host_int_evarb

Overview:
- Upstream producer for the host interrupt event queue.
- Collects single-cycle event pulses from NUM_SRC sources and keeps a saturating per-source pending count.
- Round-robin arbitrates among the sources and emits one event code per accepted transfer on a registered valid/ready interface, which feeds the event queue input (i_pd/i_pvld/i_prdy).
- Supplies sticky per-source overflow status and an idle indication for clock gating.

Parameters:
- EV_W, 2, event code width; NUM_SRC = 2**EV_W (4 by default).
- CNT_W, 4, pending counter width per source; saturates at 2**CNT_W-1 (15).

Ports:
- sysclk_slcg  input  1  clock.
- reset_  input  1  reset, asynchronous assert, active-low.
- ev_req  input  NUM_SRC  per-source event pulse; one event per bit per cycle.
- o_pd  output  EV_W  event code (source index); to event queue i_pd.
- o_pvld  output  1  o_pd valid; to event queue i_pvld.
- o_prdy  input  1  downstream ready; from event queue i_prdy.
- ovf  output  NUM_SRC  sticky overflow flag per source.
- ovf_clr  input  NUM_SRC  per-source overflow clear pulse.
- o_idle  output  1  high when no event is pending and none is in flight.

Behaviour:
- Reset (reset_ low, async):
  - cnt[*]=0, o_pvld=0, o_pd=0, ovf=0.
  - rr_ptr=NUM_SRC-1, so source 0 wins first.
  - o_idle=1.
- Pending counters, per source i, updated each clock:
  - inc = ev_req[i]; dec = source i selected for load this cycle.
  - inc && dec: cnt unchanged. inc only: cnt+1. dec only: cnt-1.
  - inc only with cnt at max: cnt holds at max, the event is dropped, and ovf[i] sets.
  - A counter is never decremented below 0, because only sources with cnt!=0 are eligible.
- Overflow flags:
  - ovf[i] is sticky and cleared by ovf_clr[i].
  - Set and clear in the same cycle: set wins (ovf stays 1).
- Output register:
  - load_en = (!o_pvld || o_prdy) && (any cnt!=0).
  - On load_en: o_pd <= selected index, o_pvld <= 1, that source's cnt decrements, rr_ptr <= selected index.
  - On (o_pvld && o_prdy && no eligible source): o_pvld <= 0. o_pd holds its last value.
  - While o_pvld && !o_prdy: o_pd and o_pvld hold stable. No counter decrements.
  - Full throughput: one event per cycle while o_prdy=1 and events are pending.
- Arbitration:
  - Round-robin. Search eligible sources in order rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC; the first with cnt!=0 wins.
  - rr_ptr updates only on load.
- Latency:
  - ev_req sampled at edge N increments cnt at edge N. The source is eligible during cycle N+1 and o_pvld rises at edge N+1.
  - The minimum is 2 edges from pulse to o_pvld.
  - No combinational path from ev_req or o_prdy to o_pd/o_pvld.
  - o_prdy reaches the counters and load logic only.
- o_idle = !o_pvld && (all cnt==0). Combinational from registers only.
- Reset mid-operation:
  - Everything clears immediately; in-flight and pending events are discarded.
  - After reset deassert, the first load occurs no earlier than 2 edges after the next ev_req.

Optional Feature:
- Macro: NV_HOST_INT_EVARB_PRIO0_EN.
- Defined: source 0 has absolute priority. If cnt[0]!=0 it is selected regardless of rr_ptr. Remaining sources (1..NUM_SRC-1) are round-robin among themselves, and rr_ptr updates only on grants to sources 1..NUM_SRC-1.
- Undefined: pure round-robin across all sources, as in Behaviour.
- Ports, latency and counter rules are identical in both builds.

Test Plan:
- Reset then single ev_req=4'b0100 with o_prdy=1: o_pvld=1, o_pd=2 exactly 2 edges after the pulse, for 1 cycle. o_idle is 0 during that window and 1 afterwards.
- ev_req=4'b1111 for 1 cycle with o_prdy=1: o_pd sequence 0,1,2,3 on consecutive cycles, then o_pvld=0. Repeating with rr_ptr left at 1 gives 2,3,0,1.
- o_prdy=0 while ev_req[1] pulses 20 times: o_pd=1 held stable with o_pvld=1 and cnt[1] saturates at 15. ovf[1]=1. Then o_prdy=1 yields exactly 16 transfers of code 1 (1 in flight + 15).
- ovf_clr[1] and a saturating ev_req[1] in the same cycle: ovf[1] stays 1. ovf_clr[1] alone: ovf[1]=0 the next cycle.
- ev_req[3] pulsed every cycle with o_prdy=1 continuous: after the first o_pvld, one transfer per cycle and cnt[3] stays at 1 (inc and dec together). Asserting reset_ mid-stream: o_pvld=0, ovf=0 and o_idle=1 immediately.
- NV_HOST_INT_EVARB_PRIO0_EN defined, ev_req=4'b1111 twice back-to-back, o_prdy=1: both source-0 events are issued before any source 1/2/3 event. Undefined: the same stimulus yields interleaved round-robin order.

Source files
------------

// File: rtl/nv_host_int_evarb.sv
// Host interrupt event arbiter: per-source saturating pending counters, round-robin
// selection and a registered valid/ready output. Optional macro: NV_HOST_INT_EVARB_PRIO0_EN.
module nv_host_int_evarb #(
    parameter  int EV_W    = 2,
    parameter  int CNT_W   = 4,
    localparam int NUM_SRC = 2**EV_W
) (
    input  logic               sysclk_slcg,
    input  logic               reset_,
    input  logic [NUM_SRC-1:0] ev_req,
    output logic [EV_W-1:0]    o_pd,
    output logic               o_pvld,
    input  logic               o_prdy,
    output logic [NUM_SRC-1:0] ovf,
    input  logic [NUM_SRC-1:0] ovf_clr,
    output logic               o_idle
);

`ifdef NV_HOST_INT_EVARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    // With source-0 priority, the round-robin search only considers sources 1..NUM_SRC-1
    localparam logic [NUM_SRC-1:0] RR_MASK = PRIO0 ? {{(NUM_SRC-1){1'b1}}, 1'b0} : '1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt [NUM_SRC];
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] rr_cand;
    logic [NUM_SRC-1:0] dec;
    logic [NUM_SRC-1:0] ovf_set;
    logic [EV_W-1:0]    rr_ptr;
    logic [EV_W-1:0]    sel;
    logic [EV_W-1:0]    idx;
    logic               found;
    logic               any_elig;
    logic               load_en;
    logic               rr_upd;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = (cnt[i] != '0);
        end
        rr_cand  = elig & RR_MASK;
        any_elig = |elig;
    end

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        if (PRIO0 && elig[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = rr_ptr + EV_W'(k);
            if (!found && rr_cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign load_en = (!o_pvld || o_prdy) && any_elig;
    assign rr_upd  = load_en && !(PRIO0 && (sel == '0));
    assign o_idle  = !o_pvld && !any_elig;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            dec[i]     = load_en && (sel == EV_W'(i));
            ovf_set[i] = ev_req[i] && !dec[i] && (cnt[i] == CNT_MAX);
        end
    end

    // An event arriving in the same cycle as a grant cancels out, so a saturated
    // counter only drops events when it is not being drained
    always_ff @(posedge sysclk_slcg or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (ev_req[i] && !dec[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!ev_req[i] && dec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    always_ff @(posedge sysclk_slcg or negedge reset_) begin
        if (!reset_) begin
            o_pd   <= '0;
            o_pvld <= 1'b0;
            rr_ptr <= EV_W'(NUM_SRC - 1);
        end else begin
            if (load_en) begin
                o_pd   <= sel;
                o_pvld <= 1'b1;
            end else if (o_prdy) begin
                o_pvld <= 1'b0;
            end
            if (rr_upd) begin
                rr_ptr <= sel;
            end
        end
    end

endmodule

// File: tb/tb_nv_host_int_evarb.sv
// Testbench for nv_host_int_evarb: table-driven per-cycle vectors plus hand-written
// saturation, streaming, reset and priority sequences, with a transfer scoreboard.
module tb_nv_host_int_evarb;

    logic       sysclk_slcg = 1'b0;
    logic       reset_      = 1'b0;
    logic [3:0] ev_req      = '0;
    logic [3:0] ovf_clr     = '0;
    logic       o_prdy      = 1'b0;
    logic [1:0] o_pd;
    logic       o_pvld;
    logic       o_idle;
    logic [3:0] ovf;

    int         total    = 0;
    int         bad      = 0;
    int         xfer_cnt = 0;
    logic [1:0] sb_q[$];

    typedef struct {
        string           name;
        bit              do_rst;
        logic [3:0]      ev;
        logic            prdy;
        int              npush;
        logic [3:0][1:0] codes;
        logic            exp_pvld;
        logic [1:0]      exp_pd;
        logic            exp_idle;
    } vec_t;

    vec_t vecs[$];

    nv_host_int_evarb dut (
        .sysclk_slcg (sysclk_slcg),
        .reset_      (reset_),
        .ev_req      (ev_req),
        .o_pd        (o_pd),
        .o_pvld      (o_pvld),
        .o_prdy      (o_prdy),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .o_idle      (o_idle)
    );

    always #5 sysclk_slcg = ~sysclk_slcg;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input logic pvld, input logic [1:0] pd, input logic idle);
        check({name, ".o_pvld"}, 32'(o_pvld), 32'(pvld));
        check({name, ".o_pd"},   32'(o_pd),   32'(pd));
        check({name, ".o_idle"}, 32'(o_idle), 32'(idle));
    endtask

    // Drive one cycle; any handshake before the edge is scored against the queue
    task automatic applyStimulus(input logic [3:0] ev, input logic prdy, input logic [3:0] clr);
        ev_req  = ev;
        o_prdy  = prdy;
        ovf_clr = clr;
        #1;
        if (o_pvld && o_prdy) begin
            xfer_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_empty: got transfer code %0d want no transfer", o_pd);
            end else begin
                check("sb_code", 32'(o_pd), 32'(sb_q.pop_front()));
            end
        end
        @(posedge sysclk_slcg);
        #1;
    endtask

    task automatic do_reset();
        reset_  = 1'b0;
        ev_req  = '0;
        ovf_clr = '0;
        o_prdy  = 1'b1;
        sb_q.delete();
        @(posedge sysclk_slcg);
        #1;
        reset_ = 1'b1;
        checkOutput("reset", 1'b0, 2'd0, 1'b1);
        check("reset.ovf", 32'(ovf), 32'd0);
    endtask

    function automatic void add(input string name, input bit rst, input logic [3:0] ev, input int npush,
                                input logic [7:0] codes, input logic pvld, input logic [1:0] pd,
                                input logic idle);
        vec_t v;
        v.name     = name;
        v.do_rst   = rst;
        v.ev       = ev;
        v.prdy     = 1'b1;
        v.npush    = npush;
        v.codes    = codes;
        v.exp_pvld = pvld;
        v.exp_pd   = pd;
        v.exp_idle = idle;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [1:0] a0, a1, a2, a3;
        logic [1:0] prio_seq[$];

`ifdef NV_HOST_INT_EVARB_PRIO0_EN
        a0 = 2'd0; a1 = 2'd2; a2 = 2'd3; a3 = 2'd1;
        prio_seq = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
        a0 = 2'd2; a1 = 2'd3; a2 = 2'd0; a3 = 2'd1;
        prio_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif

        // Single pulse latency
        add("single0", 1, 4'b0000, 0, 8'h00,            0, 2'd0, 1);
        add("single1", 0, 4'b0100, 1, 8'h02,            0, 2'd0, 0);
        add("single2", 0, 4'b0000, 0, 8'h00,            1, 2'd2, 0);
        add("single3", 0, 4'b0000, 0, 8'h00,            0, 2'd2, 1);
        add("single4", 0, 4'b0000, 0, 8'h00,            0, 2'd2, 1);
        // All sources once, then again with rr_ptr parked at 1
        add("all0",    1, 4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 0, 2'd0, 0);
        add("all1",    0, 4'b0000, 0, 8'h00,            1, 2'd0, 0);
        add("all2",    0, 4'b0000, 0, 8'h00,            1, 2'd1, 0);
        add("all3",    0, 4'b0000, 0, 8'h00,            1, 2'd2, 0);
        add("all4",    0, 4'b0000, 0, 8'h00,            1, 2'd3, 0);
        add("all5",    0, 4'b0000, 0, 8'h00,            0, 2'd3, 1);
        add("park0",   0, 4'b0010, 1, 8'h01,            0, 2'd3, 0);
        add("park1",   0, 4'b0000, 0, 8'h00,            1, 2'd1, 0);
        add("rep0",    0, 4'b1111, 4, {a3, a2, a1, a0}, 0, 2'd1, 0);
        add("rep1",    0, 4'b0000, 0, 8'h00,            1, a0,   0);
        add("rep2",    0, 4'b0000, 0, 8'h00,            1, a1,   0);
        add("rep3",    0, 4'b0000, 0, 8'h00,            1, a2,   0);
        add("rep4",    0, 4'b0000, 0, 8'h00,            1, a3,   0);
        add("rep5",    0, 4'b0000, 0, 8'h00,            0, a3,   1);

        @(posedge sysclk_slcg);
        #1;
        foreach (vecs[n]) begin
            if (vecs[n].do_rst) do_reset();
            for (int j = 0; j < vecs[n].npush; j++) sb_q.push_back(vecs[n].codes[j]);
            applyStimulus(vecs[n].ev, vecs[n].prdy, 4'b0000);
            checkOutput(vecs[n].name, vecs[n].exp_pvld, vecs[n].exp_pd, vecs[n].exp_idle);
        end
        check("table.sb_left", 32'(sb_q.size()), 32'd0);

        // Backpressure with saturation of source 1
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            if (i <= 16) sb_q.push_back(2'd1);
            applyStimulus(4'b0010, 1'b0, 4'b0000);
            if (i == 1)  checkOutput("sat.first", 1'b0, 2'd0, 1'b0);
            if (i >= 2)  checkOutput("sat.hold", 1'b1, 2'd1, 1'b0);
            if (i == 16) check("sat.ovf_pre", 32'(ovf), 32'd0);
            if (i == 17) check("sat.ovf_set", 32'(ovf), 32'b0010);
        end
        applyStimulus(4'b0010, 1'b0, 4'b0010);
        check("ovf.set_wins", 32'(ovf), 32'b0010);
        applyStimulus(4'b0000, 1'b0, 4'b0010);
        check("ovf.clear", 32'(ovf), 32'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0000);
        check("ovf.reset_again", 32'(ovf), 32'b0010);
        checkOutput("sat.still_held", 1'b1, 2'd1, 1'b0);
        xfer_cnt = 0;
        for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 1'b1, 4'b0000);
        check("drain.count", 32'(xfer_cnt), 32'd16);
        check("drain.sb_left", 32'(sb_q.size()), 32'd0);
        checkOutput("drain.idle", 1'b0, 2'd1, 1'b1);

        // Continuous stream from source 3, then reset mid-stream
        xfer_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            sb_q.push_back(2'd3);
            applyStimulus(4'b1000, 1'b1, 4'b0000);
            if (i >= 2) checkOutput("stream", 1'b1, 2'd3, 1'b0);
        end
        check("stream.count", 32'(xfer_cnt), 32'd8);
        reset_ = 1'b0;
        #1;
        checkOutput("async_rst", 1'b0, 2'd0, 1'b1);
        check("async_rst.ovf", 32'(ovf), 32'd0);
        sb_q.delete();
        @(posedge sysclk_slcg);
        #1;
        ev_req = '0;
        reset_ = 1'b1;
        sb_q.push_back(2'd0);
        applyStimulus(4'b0001, 1'b1, 4'b0000);
        checkOutput("post_rst.e1", 1'b0, 2'd0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput("post_rst.e2", 1'b1, 2'd0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        checkOutput("post_rst.e3", 1'b0, 2'd0, 1'b1);

        // Two back-to-back all-source bursts: order depends on source-0 priority
        do_reset();
        xfer_cnt = 0;
        foreach (prio_seq[k]) sb_q.push_back(prio_seq[k]);
        applyStimulus(4'b1111, 1'b1, 4'b0000);
        applyStimulus(4'b1111, 1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) applyStimulus(4'b0000, 1'b1, 4'b0000);
        check("burst.count", 32'(xfer_cnt), 32'd8);
        check("burst.sb_left", 32'(sb_q.size()), 32'd0);
        checkOutput("burst.idle", 1'b0, 2'd3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
